// File: rtl/instr_fetch_decode.sv
// Fetch/decode stage ahead of the CVP14 execute core: owns the PC, resolves j/nop, issues decoded fields.
// Optional build macro ILLEGAL_OP_HALT_EN: opcodes 1001-1110 halt fetch instead of acting as nop.
module instr_fetch_decode #(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(16'h0000)
) (
    input  logic              Clk,
    input  logic              Reset_n,
    output logic [ADDR_W-1:0] Addr,
    output logic              RD,
    input  logic [15:0]       DataIn,
    input  logic              MemAck,
    input  logic              MemBusy,
    output logic              IssueValid,
    input  logic              IssueReady,
    output logic [3:0]        Opcode,
    output logic [2:0]        DstReg,
    output logic [2:0]        SrcReg1,
    output logic [2:0]        SrcReg2,
    output logic [7:0]        Imm8,
    output logic [ADDR_W-1:0] InstrPC,
    output logic              Halt
);

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned OP_W    = 4;
    localparam logic [OP_W-1:0] OP_J = 4'b1000;
`ifdef ILLEGAL_OP_HALT_EN
    localparam logic [OP_W-1:0] OP_NOP = 4'b1111;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_HALTED
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [ADDR_W-1:0]    r_pc, w_pc_nxt;
    logic [ADDR_W-1:0]    r_instr_pc, w_instr_pc_nxt;
    logic [INSTR_W-1:0]   r_ir, w_ir_nxt;
    logic                 r_rd, w_rd_nxt;
    logic                 r_issue_valid, w_issue_valid_nxt;
    logic [OP_W-1:0]      w_op;
    logic [ADDR_W-1:0]    w_jmp_off;
`ifdef ILLEGAL_OP_HALT_EN
    logic                 r_halt, w_halt_nxt;
`endif

    assign w_op      = DataIn[15:12];
    assign w_jmp_off = ADDR_W'($signed(DataIn[11:0]));

    // Next-state and next-output logic; every register is loaded from here
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_instr_pc_nxt    = r_instr_pc;
        w_ir_nxt          = r_ir;
        w_rd_nxt          = 1'b0;
        w_issue_valid_nxt = 1'b0;
`ifdef ILLEGAL_OP_HALT_EN
        w_halt_nxt        = r_halt;
`endif
        unique case (r_state)
            S_IDLE: w_state_nxt = S_FETCH;
            S_FETCH: begin
                if (!MemBusy) begin
                    w_rd_nxt    = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (MemAck) begin
                    w_ir_nxt       = DataIn;
                    w_instr_pc_nxt = r_pc;
                    w_state_nxt    = S_FETCH;
                    w_pc_nxt       = r_pc + ADDR_W'(1);
                    if (w_op == OP_J) begin
                        w_pc_nxt = r_pc + w_jmp_off;
                    end else if (!w_op[3]) begin
                        w_state_nxt       = S_ISSUE;
                        w_issue_valid_nxt = 1'b1;
                    end
`ifdef ILLEGAL_OP_HALT_EN
                    else if (w_op != OP_NOP) begin
                        // PC stays on the offending instruction for debug
                        w_pc_nxt    = r_pc;
                        w_state_nxt = S_HALTED;
                        w_halt_nxt  = 1'b1;
                    end
`endif
                end else begin
                    w_rd_nxt = 1'b1;
                end
            end
            S_ISSUE: begin
                if (IssueReady) begin
                    w_state_nxt = S_FETCH;
                end else begin
                    w_issue_valid_nxt = 1'b1;
                end
            end
            S_HALTED: w_state_nxt = S_HALTED;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_instr_pc    <= '0;
            r_ir          <= '0;
            r_rd          <= 1'b0;
            r_issue_valid <= 1'b0;
`ifdef ILLEGAL_OP_HALT_EN
            r_halt        <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_instr_pc    <= w_instr_pc_nxt;
            r_ir          <= w_ir_nxt;
            r_rd          <= w_rd_nxt;
            r_issue_valid <= w_issue_valid_nxt;
`ifdef ILLEGAL_OP_HALT_EN
            r_halt        <= w_halt_nxt;
`endif
        end
    end

    assign Addr       = r_pc;
    assign RD         = r_rd;
    assign IssueValid = r_issue_valid;
    assign Opcode     = r_ir[15:12];
    assign DstReg     = r_ir[11:9];
    assign SrcReg1    = r_ir[8:6];
    assign SrcReg2    = r_ir[5:3];
    assign Imm8       = r_ir[7:0];
    assign InstrPC    = r_instr_pc;
`ifdef ILLEGAL_OP_HALT_EN
    assign Halt       = r_halt;
`else
    assign Halt       = 1'b0;
`endif

endmodule
